// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_unit
// Description : Registered program counter with next-PC source selection.
//               A redirect presented while stalled is buffered and released
//               when the stall drops. Misaligned targets are replaced by the
//               trap vector. Out-of-range selects set a sticky error flag.
// Ports       : clock, reset   - rising-edge clock, synchronous active-high reset
//               src            - N_SRC packed candidate PCs (src 0 = fall-through)
//               sel            - source select
//               stall, flush   - hold PC / force PC to TRAP_VEC
//               pc, pc_next    - registered PC and the value it takes next edge
//               pend_valid     - a redirect is buffered awaiting stall release
//               sel_err        - sticky out-of-range select flag
//               misalign       - one-cycle pulse after a misaligned substitution
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_unit #(
    parameter int                 WIDTH    = 32,
    parameter int                 N_SRC    = 5,
    parameter int                 SEL_W    = 3,
    parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   TRAP_VEC = 32'h8000_0180
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   stall,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       pc_next,
    output logic                   pend_valid,
    output logic                   sel_err,
    output logic                   misalign
);

    typedef enum logic [0:0] {
        c_run  = 1'b0,
        c_pend = 1'b1
    } state_t;

    // Source count widened by one bit so the range compare never truncates.
    localparam logic [SEL_W:0] c_n_src = N_SRC[SEL_W:0];

    state_t             r_state;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_pend_pc;
    logic               r_sel_err;
    logic               r_misalign;

    logic               w_sel_valid;
    logic               w_sel_zero;
    logic               w_redirect;
    logic [WIDTH-1:0]   w_target;
    logic [WIDTH-1:0]   w_cand;
    logic               w_load;
    logic [WIDTH-1:0]   w_pc_next;
    state_t             w_state_next;
    logic [WIDTH-1:0]   w_pend_next;
    logic               w_sel_err_next;
    logic               w_misalign_next;

    assign w_sel_valid = ({1'b0, sel} < c_n_src);
    assign w_sel_zero  = (sel == '0);
    assign w_redirect  = w_sel_valid && !w_sel_zero;

    // Candidate target mux; an invalid select yields zero and is never used.
    always_comb begin
        w_target = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if ({1'b0, sel} == (SEL_W+1)'(k)) begin
                w_target = src[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic. w_load marks an edge where pc takes w_cand, which is
    // the only path subject to the alignment check (reset/flush constants
    // bypass it).
    always_comb begin
        w_pc_next       = r_pc;
        w_state_next    = r_state;
        w_pend_next     = r_pend_pc;
        w_sel_err_next  = r_sel_err;
        w_misalign_next = 1'b0;
        w_load          = 1'b0;
        w_cand          = '0;

        if (reset) begin
            w_pc_next      = RESET_PC;
            w_state_next   = c_run;
            w_pend_next    = '0;
            w_sel_err_next = 1'b0;
        end else if (flush) begin
            w_pc_next    = TRAP_VEC;
            w_state_next = c_run;
        end else if (!stall) begin
            w_state_next = c_run;
            if (w_sel_valid) begin
                w_load = 1'b1;
                // Fall-through while pending releases the buffered redirect;
                // any fresh redirect overrides it.
                if (r_state == c_pend && w_sel_zero) begin
                    w_cand = r_pend_pc;
                end else begin
                    w_cand = w_target;
                end
            end else begin
                w_sel_err_next = 1'b1;
                if (r_state == c_pend) begin
                    w_load = 1'b1;
                    w_cand = r_pend_pc;
                end
            end
        end else if (w_redirect) begin
            // Stalled redirect: latest one wins, checked only on release.
            w_pend_next  = w_target;
            w_state_next = c_pend;
        end

        if (w_load) begin
            if (w_cand[1:0] != 2'b00) begin
                w_pc_next       = TRAP_VEC;
                w_misalign_next = 1'b1;
            end else begin
                w_pc_next = w_cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_run;
            r_pc       <= RESET_PC;
            r_pend_pc  <= '0;
            r_sel_err  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pend_pc  <= w_pend_next;
            r_sel_err  <= w_sel_err_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc         = r_pc;
    assign pc_next    = w_pc_next;
    assign pend_valid = (r_state == c_pend);
    assign sel_err    = r_sel_err;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_next_pc_unit
// Description : Directed self-checking bench for next_pc_unit (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_next_pc_unit;

    localparam int c_width = 32;
    localparam int c_n_src = 5;
    localparam int c_sel_w = 3;
    localparam logic [31:0] c_trap = 32'h8000_0180;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [c_n_src*c_width-1:0] src;
    logic [c_sel_w-1:0]         sel;
    logic                       stall;
    logic                       flush;
    logic [c_width-1:0]         pc;
    logic [c_width-1:0]         pc_next;
    logic                       pend_valid;
    logic                       sel_err;
    logic                       misalign;

    int checks = 0;
    int errors = 0;

    next_pc_unit #(
        .WIDTH    (c_width),
        .N_SRC    (c_n_src),
        .SEL_W    (c_sel_w),
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (c_trap)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .src        (src),
        .sel        (sel),
        .stall      (stall),
        .flush      (flush),
        .pc         (pc),
        .pc_next    (pc_next),
        .pend_valid (pend_valid),
        .sel_err    (sel_err),
        .misalign   (misalign)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        src[k*c_width +: c_width] = v;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; src = '0; sel = '0; stall = 1'b0; flush = 1'b0;
        set_src(0, 32'h4);
        #1;
        check("pc_next_in_reset", pc_next, 32'h0);
        tick();
        check("reset_pc", pc, 32'h0);
        check("reset_pend", {31'b0, pend_valid}, 32'h0);
        check("reset_selerr", {31'b0, sel_err}, 32'h0);
        check("reset_misalign", {31'b0, misalign}, 32'h0);

        // Sequential fall-through
        reset = 1'b0; #1;
        check("pc_next_seq", pc_next, 32'h4);
        tick();
        check("pc_seq", pc, 32'h4);

        // Stalled redirect buffered, released on fall-through
        set_src(0, 32'h8); stall = 1'b1; sel = 3'd2; set_src(2, 32'h100); #1;
        check("pc_next_stall", pc_next, 32'h4);
        tick();
        check("pc_held", pc, 32'h4);
        check("pend_set", {31'b0, pend_valid}, 32'h1);
        stall = 1'b0; sel = 3'd0; #1;
        check("pc_next_release", pc_next, 32'h100);
        tick();
        check("pc_release", pc, 32'h100);
        check("pend_clear", {31'b0, pend_valid}, 32'h0);

        // New redirect beats pending one
        stall = 1'b1; sel = 3'd2; tick();
        check("pend_again", {31'b0, pend_valid}, 32'h1);
        stall = 1'b0; sel = 3'd3; set_src(3, 32'h200); #1;
        check("pc_next_override", pc_next, 32'h200);
        tick();
        check("pc_override", pc, 32'h200);
        check("pend_discard", {31'b0, pend_valid}, 32'h0);
        sel = 3'd0; set_src(0, 32'h204); tick();
        check("no_stale_release", pc, 32'h204);

        // Latest stalled redirect wins; stalled fall-through keeps it
        stall = 1'b1; sel = 3'd1; set_src(1, 32'h300); tick();
        sel = 3'd4; set_src(4, 32'h400); tick();
        sel = 3'd0; tick();
        check("pc_held_pend", pc, 32'h204);
        stall = 1'b0; tick();
        check("latest_wins", pc, 32'h400);

        // Invalid select: hold and sticky error
        sel = 3'd5; #1;
        check("pc_next_badsel", pc_next, 32'h400);
        tick();
        check("badsel_hold", pc, 32'h400);
        check("selerr_set", {31'b0, sel_err}, 32'h1);
        sel = 3'd0; set_src(0, 32'h404); tick();
        check("pc_after_badsel", pc, 32'h404);
        check("selerr_sticky", {31'b0, sel_err}, 32'h1);

        // Invalid select while pending releases the pending value
        stall = 1'b1; sel = 3'd2; set_src(2, 32'h500); tick();
        stall = 1'b0; sel = 3'd6; tick();
        check("badsel_release", pc, 32'h500);
        check("badsel_pend_clear", {31'b0, pend_valid}, 32'h0);

        // Misaligned direct target
        sel = 3'd1; set_src(1, 32'h102); #1;
        check("pc_next_misalign", pc_next, c_trap);
        tick();
        check("pc_misalign", pc, c_trap);
        check("misalign_pulse", {31'b0, misalign}, 32'h1);
        sel = 3'd0; set_src(0, 32'h8000_0184); tick();
        check("misalign_drop", {31'b0, misalign}, 32'h0);
        check("pc_after_trap", pc, 32'h8000_0184);

        // Misaligned pending value checked at release, not capture
        stall = 1'b1; sel = 3'd3; set_src(3, 32'h601); tick();
        check("no_misalign_capture", {31'b0, misalign}, 32'h0);
        stall = 1'b0; sel = 3'd0; tick();
        check("pc_pend_misalign", pc, c_trap);
        check("pend_misalign_pulse", {31'b0, misalign}, 32'h1);

        // Flush with stall while pending
        stall = 1'b1; sel = 3'd2; set_src(2, 32'h700); tick();
        flush = 1'b1; #1;
        check("pc_next_flush", pc_next, c_trap);
        tick();
        check("pc_flush", pc, c_trap);
        check("flush_pend", {31'b0, pend_valid}, 32'h0);
        flush = 1'b0; stall = 1'b0; sel = 3'd0; set_src(0, 32'h800); tick();
        check("no_release_after_flush", pc, 32'h800);

        // Reset in pending clears everything
        stall = 1'b1; sel = 3'd2; set_src(2, 32'h900); tick();
        reset = 1'b1; #1;
        check("pc_next_reset_pend", pc_next, 32'h0);
        tick();
        check("pc_reset_pend", pc, 32'h0);
        check("pend_after_reset", {31'b0, pend_valid}, 32'h0);
        check("selerr_reset", {31'b0, sel_err}, 32'h0);

        // Flush ignores an invalid select; then no stale release
        reset = 1'b0; flush = 1'b1; stall = 1'b0; sel = 3'd5; tick();
        check("pc_flush2", pc, c_trap);
        check("flush_no_selerr", {31'b0, sel_err}, 32'h0);
        flush = 1'b0; sel = 3'd0; set_src(0, 32'hA00); tick();
        check("no_release_after_reset", pc, 32'hA00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
